// File: rtl/fetch_queue_if.sv
// fetch_queue_if: ROM, redirect and downstream handshake bundle for fetch_queue.
//   master: fetch_queue side (drives rom_addr_o, instr_valid_o, instr_o, pc_o, inc_pc_o, count_o)
//   slave : environment side (drives rom_data_i, redirect_i, redirect_pc_i, instr_ready_i)
interface fetch_queue_if #(
  parameter int DW = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DW-1:0] rom_addr_o;
  logic [DW-1:0] rom_data_i;
  logic redirect_i;
  logic [DW-1:0] redirect_pc_i;
  logic instr_ready_i;
  logic instr_valid_o;
  logic [DW-1:0] instr_o;
  logic [DW-1:0] pc_o;
  logic [DW-1:0] inc_pc_o;
  logic [CW-1:0] count_o;
  modport master (
    output rom_addr_o, instr_valid_o, instr_o, pc_o, inc_pc_o, count_o,
    input rom_data_i, redirect_i, redirect_pc_i, instr_ready_i
  );
  modport slave (
    input rom_addr_o, instr_valid_o, instr_o, pc_o, inc_pc_o, count_o,
    output rom_data_i, redirect_i, redirect_pc_i, instr_ready_i
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: PC owner + ROM driver + DEPTH-entry {pc, instr} FIFO ahead of decode.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : fetch_queue_if.master (ROM address/data, redirect, head entry handshake, occupancy)
//   Optional FETCHQ_BYPASS_EN: empty queue presents {fetch PC, rom_data_i} combinationally.
module fetch_queue #(
  parameter int DW = 32,
  parameter int DEPTH = 4,
  parameter logic [DW-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] slot_pc_q [DEPTH];
  logic [DW-1:0] slot_pc_d [DEPTH];
  logic [DW-1:0] slot_instr_q [DEPTH];
  logic [DW-1:0] slot_instr_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic bypass, valid, pop, take, push;
  always_comb begin
    bypass = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    // gated by rst so the output stays quiet while reset is held
    bypass = rst && cnt_q == '0 && !bus.redirect_i;
`endif
    valid = (cnt_q != '0 || bypass) && !bus.redirect_i;
    pop = valid && bus.instr_ready_i && !bypass;
    // a bypassed entry consumed in the same cycle never touches storage
    take = bypass && bus.instr_ready_i;
    push = !bus.redirect_i && !take && (cnt_q < CW'(DEPTH) || pop);
    pc_d = bus.redirect_i ? {bus.redirect_pc_i[DW-1:2], 2'b00}
         : (push || take) ? pc_q + DW'(4) : pc_q;
    rd_d = bus.redirect_i ? '0 : pop ? rd_q + AW'(1) : rd_q;
    wr_d = bus.redirect_i ? '0 : push ? wr_q + AW'(1) : wr_q;
    cnt_d = bus.redirect_i ? '0 : cnt_q + CW'(push) - CW'(pop);
    slot_pc_d = slot_pc_q;
    slot_instr_d = slot_instr_q;
    if (push) begin
      slot_pc_d[wr_q] = pc_q;
      slot_instr_d[wr_q] = bus.rom_data_i;
    end
  end
  assign bus.rom_addr_o = pc_q;
  assign bus.instr_valid_o = valid;
  assign bus.instr_o = bypass ? bus.rom_data_i : slot_instr_q[rd_q];
  assign bus.pc_o = bypass ? pc_q : slot_pc_q[rd_q];
  assign bus.inc_pc_o = bus.pc_o + DW'(4);
  assign bus.count_o = cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      slot_pc_q <= '{default: '0};
      slot_instr_q <= '{default: '0};
    end else begin
      pc_q <= pc_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      slot_pc_q <= slot_pc_d;
      slot_instr_q <= slot_instr_d;
    end
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front-end that owns the program counter, drives the combinational instruction ROM, and buffers fetched instructions in a small FIFO ahead of the fetch pipeline register. It sits upstream of the fetch/decode pipeline register. It decouples fetch from decode back-pressure and flushes on taken branch/jump redirects from execute.

## Interface
- DW, 32, data/address width
- DEPTH, 4, FIFO entries (power of two, ≥2)
- RESET_PC, 32'h0, first fetch address after reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- rom_addr_o  out  DW  fetch address to ROM (= fetch PC)
- rom_data_i  in  DW  ROM read data, combinational from rom_addr_o
- redirect_i  in  1  taken branch/jump from execute
- redirect_pc_i  in  DW  redirect target
- instr_ready_i  in  1  downstream accepts head entry this cycle
- instr_valid_o  out  1  head entry valid
- instr_o  out  DW  head instruction
- pc_o  out  DW  head instruction address
- inc_pc_o  out  DW  pc_o + 4
- count_o  out  $clog2(DEPTH+1)  occupancy

## Operation
- State: fetch PC register, DEPTH×{pc, instr} storage, read pointer, write pointer, count.
- Pop: instr_valid_o && instr_ready_i. Removes head entry; read pointer advances modulo DEPTH.
- Push: !redirect_i && (count < DEPTH || pop). Writes {fetch PC, rom_data_i} at the write pointer; write pointer advances modulo DEPTH; fetch PC += 4 (wraps modulo 2^DW).
- Full with simultaneous pop: push is allowed and count is unchanged.
- No push: fetch PC holds and rom_addr_o holds.
- instr_valid_o = (count != 0) && !redirect_i. No handshake completes in a redirect cycle.
- Redirect (priority over push/pop):
  - Next edge: count = 0, both pointers = 0.
  - fetch PC = {redirect_pc_i[DW-1:2], 2'b00}; low two bits are ignored.
- instr_o/pc_o reflect the head slot even when invalid. Contents are meaningful only when valid.
- count_o = count register.

## Timing
- Reset values (asynchronous, immediate on rst low):
  - fetch PC = RESET_PC
  - count = 0
  - pointers = 0
  - all storage = 0
  - instr_valid_o = 0
  - instr_o = 0, pc_o = 0, inc_pc_o = 4
  - rom_addr_o = RESET_PC
- Fetch-to-valid latency:
  - Entry pushed at edge N is visible with instr_valid_o = 1 in cycle N+1.
  - First valid after reset release: one cycle after the first edge.
- Redirect latency: redirect_i high in cycle R.
  - R+1: rom_addr_o = target, count = 0, valid = 0.
  - R+2: valid = 1 with pc_o = target.
- Steady state with instr_ready_i held high: one instruction per cycle.
- rst assertion mid-operation discards all entries regardless of handshake in progress.

## Configuration
- FETCHQ_BYPASS_EN defined:
  - When count == 0 and !redirect_i, the output presents {fetch PC, rom_data_i} combinationally with instr_valid_o = 1.
  - If instr_ready_i is high, the entry is consumed without being written (no push; fetch PC += 4). Otherwise it is pushed normally.
  - Redirect latency drops to valid in R+1; post-reset valid in the first cycle after release.
- Undefined: no bypass; behaviour exactly as above.

## Test plan
- Reset release, instr_ready_i = 1, ROM returns data = address ^ 32'hA5A5_0000 → pc_o sequence 0x0, 0x4, 0x8, … one per cycle; instr_o matches; inc_pc_o = pc_o + 4.
- instr_ready_i = 0 for 10 cycles after reset → count_o saturates at 4 and rom_addr_o holds 0x10. Then instr_ready_i = 1 → outputs 0x0, 0x4, 0x8, 0xC, 0x10 in order with no gaps or duplicates.
- Queue full, redirect_i pulsed with redirect_pc_i = 0x100 → next cycle count_o = 0 and valid = 0; cycle after: valid, pc_o = 0x100, instr_o = ROM[0x100]. No stale entry is ever presented.
- redirect_pc_i = 0x103 → pc_o = 0x100. Redirect asserted together with instr_ready_i = 1 and a valid head → no pop counted and the head is discarded.
- Full queue, instr_ready_i = 1 continuously → count_o stays 4 and addresses remain contiguous.
- rst driven low mid-stream, asynchronous to clk → instr_valid_o, count_o, instr_o and pc_o read 0 before the next edge, and rom_addr_o reads RESET_PC. With FETCHQ_BYPASS_EN, rerun the redirect case → valid with pc_o = 0x100 in R+1.
